// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if
//   Control/status bundle for the programmable clock divider.
//   master : drives enable, sync, div_load, ch_sel, div_value;
//            observes clock_out, tick, load_pending
//   slave  : the divider itself (mirror of master)
//   Signals:
//     enable       global run; 0 freezes all channels
//     sync         1-cycle pulse, restart all channels phase-aligned
//     div_load     1-cycle pulse, write div_value to channel ch_sel
//     ch_sel       target channel of div_load (out-of-range values ignored)
//     div_value    new divisor; half-period = div_value+1 cycles
//     clock_out    divided clocks, one bit per channel
//     tick         1-cycle strobe on each clock_out toggle
//     load_pending written divisor not yet active on that channel
interface prog_clock_divider_if #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned NUM_CH = 2
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic              sync;
  logic              div_load;
  logic [SEL_W-1:0]  ch_sel;
  logic [WIDTH-1:0]  div_value;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] load_pending;

  modport master (
    output enable, sync, div_load, ch_sel, div_value,
    input  clock_out, tick, load_pending
  );

  modport slave (
    input  enable, sync, div_load, ch_sel, div_value,
    output clock_out, tick, load_pending
  );
endinterface

// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//   Multi-channel programmable clock divider. Each channel divides clock_in by
//   2*(active_div+1), producing a 50%-duty clock_out and a one-cycle tick at
//   every toggle. New divisors are staged in pend_div and only take effect at
//   terminal count (or on sync), so clock_out never glitches.
//   Ports:
//     clock_in  system clock, all logic on posedge
//     reset_n   synchronous active-low reset
//     bus       prog_clock_divider_if.slave (control inputs, divided outputs)
module prog_clock_divider #(
  parameter int unsigned     WIDTH       = 24,
  parameter int unsigned     NUM_CH      = 2,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  prog_clock_divider_if.slave   bus
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0]  cnt_q  [NUM_CH];
  logic [WIDTH-1:0]  cnt_d  [NUM_CH];
  logic [WIDTH-1:0]  act_q  [NUM_CH];
  logic [WIDTH-1:0]  act_d  [NUM_CH];
  logic [WIDTH-1:0]  pend_q [NUM_CH];
  logic [WIDTH-1:0]  pend_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] lp_q, lp_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      logic             hit;
      logic [WIDTH-1:0] next_div;

      cnt_d[i]  = cnt_q[i];
      act_d[i]  = act_q[i];
      pend_d[i] = pend_q[i];
      clk_d[i]  = clk_q[i];
      tick_d[i] = 1'b0;
      lp_d[i]   = lp_q[i];

      hit = bus.div_load && (bus.ch_sel == SEL_W'(i));
      // A load landing on the same edge as an activation point bypasses the
      // staging register so the freshest value is the one made active.
      next_div = hit ? bus.div_value : pend_q[i];

      if (hit) begin
        pend_d[i] = bus.div_value;
        lp_d[i]   = 1'b1;
      end

      if (bus.sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        act_d[i] = next_div;
        lp_d[i]  = 1'b0;
      end else if (bus.enable) begin
        if (cnt_q[i] == act_q[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          act_d[i]  = next_div;
          lp_d[i]   = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        act_q[i]  <= DEFAULT_DIV;
        pend_q[i] <= DEFAULT_DIV;
      end
      clk_q  <= '0;
      tick_q <= '0;
      lp_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        act_q[i]  <= act_d[i];
        pend_q[i] <= pend_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
      lp_q   <= lp_d;
    end
  end

  assign bus.clock_out    = clk_q;
  assign bus.tick         = tick_q;
  assign bus.load_pending = lp_q;
endmodule
